pipe_stage_skid_reg: RTL and testbench

//  Generic parametrised pipeline-stage register (E/M, M/W, ...) with valid/ready handshake, 2-entry skid buffer and flush.

---
 rtl/pipe_stage_skid_reg_if.sv | 14 +
 rtl/pipe_stage_skid_reg.sv | 142 ++++++++++++++
 tb/tb_pipe_stage_skid_reg.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_skid_reg_if.sv
// Valid/ready beat channel carrying a held payload (data) and a flushable control word (ctrl).
// The master drives a beat; the slave returns ready.
interface pipe_stage_skid_reg_if #(
  parameter int DATA_W = 104,
  parameter int CTRL_W = 11
) ();
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [CTRL_W-1:0] ctrl;

  modport master (output valid, output data, output ctrl, input  ready);
  modport slave  (input  valid, input  data, input  ctrl, output ready);
endinterface

// File: rtl/pipe_stage_skid_reg.sv
// Pipeline-stage register with a 2-entry skid buffer, flush of control bits, and full throughput.
// Optional macro PIPE_PERF_CNT_EN adds saturating stall/flush cycle counters.
module pipe_stage_skid_reg #(
  parameter int DATA_W = 104,
  parameter int CTRL_W = 11
`ifdef PIPE_PERF_CNT_EN
  ,
  parameter int CNT_W  = 32
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  pipe_stage_skid_reg_if.slave  up,
  pipe_stage_skid_reg_if.master dn
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e            state_q,     state_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;

  logic in_ready;
  logic in_fire;
  logic out_valid;
  logic out_fire;

  // in_ready depends only on held state, never on dn.ready, so no combinational
  // path crosses the stage from downstream to upstream.
  assign in_ready  = rst && (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign in_fire   = up.valid && in_ready;
  assign out_fire  = out_valid && dn.ready;

  assign up.ready  = in_ready;
  assign dn.valid  = out_valid;
  assign dn.data   = main_data_q;
  assign dn.ctrl   = out_valid ? main_ctrl_q : '0;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;

    if (flush) begin
      // Flush kills every held beat; payload registers keep their contents.
      state_d     = EMPTY;
      main_ctrl_d = '0;
      skid_ctrl_d = '0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            main_data_d = up.data;
            main_ctrl_d = up.ctrl;
            state_d     = ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_data_d = up.data;
            main_ctrl_d = up.ctrl;
          end else if (in_fire) begin
            skid_data_d = up.data;
            skid_ctrl_d = up.ctrl;
            state_d     = FULL;
          end else if (out_fire) begin
            state_d     = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            main_data_d = skid_data_q;
            main_ctrl_d = skid_ctrl_q;
            state_d     = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the two entry registers are plain flops, so clearing them in reset is cheap and gives a defined out_data.
      state_q     <= EMPTY;
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Both counters saturate at all-ones and ignore flush.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (out_valid && !dn.ready && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flush && (flush_cnt_q != '1))                   flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Self-checking bench for pipe_stage_skid_reg: directed cases plus random traffic against a queue model.
// Build with PIPE_PERF_CNT_EN defined to also exercise the saturating counters (CNT_W=2).
module tb_pipe_stage_skid_reg;

  localparam int DATA_W = 104;
  localparam int CTRL_W = 11;
`ifdef PIPE_PERF_CNT_EN
  localparam int CNT_W  = 2;
`endif

  typedef struct {
    logic [DATA_W-1:0] d;
    logic [CTRL_W-1:0] c;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;

  pipe_stage_skid_reg_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) up_if ();
  pipe_stage_skid_reg_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dn_if ();

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
`endif

  pipe_stage_skid_reg #(
    .DATA_W(DATA_W),
    .CTRL_W(CTRL_W)
`ifdef PIPE_PERF_CNT_EN
    ,
    .CNT_W (CNT_W)
`endif
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .up       (up_if.slave),
    .dn       (dn_if.master)
`ifdef PIPE_PERF_CNT_EN
    ,
    .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: the stage is a FIFO of at most two beats; out_data shows the
  // head, or the last head shown once the FIFO empties (payload is never cleared).
  beat_t             mq[$];
  logic [DATA_W-1:0] m_last_data;
`ifdef PIPE_PERF_CNT_EN
  int unsigned       m_stall, m_flush;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;
`endif

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_last_data = '0;
`ifdef PIPE_PERF_CNT_EN
    m_stall = 0;
    m_flush = 0;
`endif
  endtask

  // Advance the model by one rising edge using the inputs held across that edge.
  task automatic model_edge();
    bit m_valid, m_ready, i_fire, o_fire;
    beat_t b;
    if (!rst) begin
      model_reset();
      return;
    end
    m_valid = (mq.size() != 0);
    m_ready = (mq.size() < 2);
    i_fire  = up_if.valid && m_ready;
    o_fire  = m_valid && dn_if.ready;
`ifdef PIPE_PERF_CNT_EN
    if (m_valid && !dn_if.ready && m_stall < CNT_MAX) m_stall++;
    if (flush && m_flush < CNT_MAX) m_flush++;
`endif
    if (flush) begin
      mq.delete();
    end else begin
      if (o_fire) void'(mq.pop_front());
      if (i_fire) begin
        b.d = up_if.data;
        b.c = up_if.ctrl;
        mq.push_back(b);
      end
    end
    if (mq.size() != 0) m_last_data = mq[0].d;
  endtask

  task automatic compare_outputs();
    bit exp_valid;
    exp_valid = (mq.size() != 0);
    check("out_valid", 128'(dn_if.valid), 128'(exp_valid));
    check("in_ready",  128'(up_if.ready), 128'(rst && (mq.size() < 2)));
    check("out_data",  128'(dn_if.data),  128'(exp_valid ? mq[0].d : m_last_data));
    check("out_ctrl",  128'(dn_if.ctrl),  128'(exp_valid ? mq[0].c : '0));
`ifdef PIPE_PERF_CNT_EN
    check("stall_cnt", 128'(stall_cnt), 128'(m_stall));
    check("flush_cnt", 128'(flush_cnt), 128'(m_flush));
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic drive(input bit v, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c,
                       input bit ordy, input bit fl);
    up_if.valid = v;
    up_if.data  = d;
    up_if.ctrl  = c;
    dn_if.ready = ordy;
    flush       = fl;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    #1;
    model_reset();
    compare_outputs();
    step();
    rst = 1'b1;
    #1;
  endtask

  initial begin
    logic [127:0] r;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    model_reset();

    // Reset state and release.
    #2;
    check("rst_out_valid", 128'(dn_if.valid), 128'(0));
    check("rst_out_data",  128'(dn_if.data),  128'(0));
    check("rst_out_ctrl",  128'(dn_if.ctrl),  128'(0));
    check("rst_in_ready",  128'(up_if.ready), 128'(0));
    @(negedge clk);
    step();
    rst = 1'b1;
    step();
    check("rel_in_ready", 128'(up_if.ready), 128'(1));

    // Back-to-back stream with no backpressure.
    drive(1'b1, 'h11, 'h1, 1'b1, 1'b0); step();
    check("s1_data", 128'(dn_if.data), 128'('h11));
    check("s1_rdy",  128'(up_if.ready), 128'(1));
    drive(1'b1, 'h22, 'h2, 1'b1, 1'b0); step();
    check("s2_data", 128'(dn_if.data), 128'('h22));
    drive(1'b1, 'h33, 'h3, 1'b1, 1'b0); step();
    check("s3_data", 128'(dn_if.data), 128'('h33));
    check("s3_rdy",  128'(up_if.ready), 128'(1));
    drive(1'b0, '0, '0, 1'b1, 1'b0); step();
    check("s_drain_valid", 128'(dn_if.valid), 128'(0));

    // Backpressure fills both entries, then drains in order.
    drive(1'b1, 'hA, 'h2, 1'b0, 1'b0); step();
    drive(1'b1, 'hB, 'h4, 1'b0, 1'b0); step();
    check("bp_full_rdy", 128'(up_if.ready), 128'(0));
    check("bp_head_a",   128'(dn_if.data),  128'('hA));
    drive(1'b0, '0, '0, 1'b1, 1'b0); step();
    check("bp_head_b",   128'(dn_if.data),  128'('hB));
    check("bp_rdy_back", 128'(up_if.ready), 128'(1));
    step();
    check("bp_empty", 128'(dn_if.valid), 128'(0));

    // Flush while FULL with all control bits set.
    drive(1'b1, 'hC, 'h7FF, 1'b0, 1'b0); step();
    check("fl_ctrl_before", 128'(dn_if.ctrl), 128'('h7FF));
    drive(1'b1, 'hD, 'h7FF, 1'b0, 1'b0); step();
    drive(1'b0, '0, '0, 1'b0, 1'b1); step();
    check("fl_valid", 128'(dn_if.valid), 128'(0));
    check("fl_ctrl",  128'(dn_if.ctrl),  128'(0));
    check("fl_rdy",   128'(up_if.ready), 128'(1));
    check("fl_data",  128'(dn_if.data),  128'('hC));

    // Flush discards a beat offered in the same cycle.
    apply_reset();
    drive(1'b1, 'h55, 'h5, 1'b1, 1'b1); step();
    check("f5_valid", 128'(dn_if.valid), 128'(0));
    check("f5_data",  128'(dn_if.data),  128'(0));
    drive(1'b0, '0, '0, 1'b1, 1'b0); step();
    check("f5_data2", 128'(dn_if.data),  128'(0));

`ifdef PIPE_PERF_CNT_EN
    // Stall counter saturates at 3, flush counter counts two cycles.
    apply_reset();
    drive(1'b1, 'h66, 'h6, 1'b0, 1'b0); step();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    repeat (5) step();
    check("pc_stall_sat", 128'(stall_cnt), 128'(3));
    drive(1'b0, '0, '0, 1'b1, 1'b1);
    repeat (2) step();
    check("pc_flush", 128'(flush_cnt), 128'(2));
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    step();
`endif

    // Randomised traffic with occasional flush and mid-run reset.
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      r = {$urandom, $urandom, $urandom, $urandom};
      drive(1'($urandom_range(0, 99) < 65), r[DATA_W-1:0], CTRL_W'($urandom),
            1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 99) < 5));
      if ($urandom_range(0, 299) == 0) apply_reset();
      else step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
